// File: rtl/axis_fifo_pipelined_mem_if.sv
// Storage-side bus between the AXI-stream FIFO controller and its word array.
// Signal names follow the memory's view: _i driven by the controller, _o by the memory.
interface axis_fifo_pipelined_mem_if #(
  parameter int unsigned width_p      = 8,
  parameter int unsigned addr_width_p = 12,
  parameter int unsigned pipe_p       = 2
);
  logic                    w_v_i;
  logic [addr_width_p-1:0] w_addr_i;
  logic [width_p-1:0]      w_data_i;
  logic                    r_v_i;
  logic [addr_width_p-1:0] r_addr_i;
  logic [width_p-1:0]      r_data_o;
  logic                    output_ready_i;
  logic [pipe_p-1:0]       valid_pipe_reg_i;

  modport master (
    output w_v_i, w_addr_i, w_data_i, r_v_i, r_addr_i, output_ready_i, valid_pipe_reg_i,
    input  r_data_o
  );

  modport slave (
    input  w_v_i, w_addr_i, w_data_i, r_v_i, r_addr_i, output_ready_i, valid_pipe_reg_i,
    output r_data_o
  );
endinterface

// File: rtl/axis_fifo_pipelined_mem.sv
// FIFO word array with a stall-aware read register pipeline whose stages advance
// in lockstep with the controller's valid pipeline.
module axis_fifo_pipelined_mem #(
  parameter int unsigned width_p           = 8,
  parameter int unsigned els_p             = 4096,
  parameter int unsigned pipeline_output_p = 2
) (
  input logic                         clk_i,
  input logic                         reset_i,
  axis_fifo_pipelined_mem_if.slave    bus
);
  localparam int unsigned addr_width_lp = $clog2(els_p);
  localparam int unsigned last_lp       = pipeline_output_p - 1;

  if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
    $error("els_p must be a power of two >= 2");
  end
  if (pipeline_output_p < 1) begin : g_bad_pipe
    $error("pipeline_output_p must be >= 1");
  end

  logic [width_p-1:0] mem_q  [els_p];
  logic [width_p-1:0] data_q [pipeline_output_p];
  logic [width_p-1:0] data_d [pipeline_output_p];
  logic               unused_valid0;

  // Stage 0's valid bit never gates anything: stage 0 loads only on a read.
  assign unused_valid0 = bus.valid_pipe_reg_i[0];

  // Array is never cleared; writes are suppressed while reset is held.
  always_ff @(posedge clk_i) begin
    if (!reset_i && bus.w_v_i) begin
      mem_q[addr_width_lp'(bus.w_addr_i)] <= bus.w_data_i;
    end
  end

  // Stage j advances exactly when the controller's valid bit j would.
  always_comb begin
    for (int unsigned j = 0; j < pipeline_output_p; j++) begin
      data_d[j] = data_q[j];
    end
    if (bus.r_v_i) begin
      data_d[0] = mem_q[addr_width_lp'(bus.r_addr_i)];
    end
    for (int unsigned j = 1; j < pipeline_output_p; j++) begin
      if (bus.output_ready_i || !bus.valid_pipe_reg_i[j]) begin
        data_d[j] = data_q[j-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned j = 0; j < pipeline_output_p; j++) begin
        data_q[j] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < pipeline_output_p; j++) begin
        data_q[j] <= data_d[j];
      end
    end
  end

  assign bus.r_data_o = data_q[last_lp];
endmodule

// File: tb/tb_axis_fifo_pipelined_mem.sv
// Scoreboard bench for axis_fifo_pipelined_mem at P=2, P=3 and P=1.
module tb_axis_fifo_pipelined_mem;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sb2[$];
  logic [7:0] sb3[$];
  logic [7:0] sb1[$];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  axis_fifo_pipelined_mem_if #(.width_p(8), .addr_width_p(4), .pipe_p(2)) if2 ();
  axis_fifo_pipelined_mem_if #(.width_p(8), .addr_width_p(4), .pipe_p(3)) if3 ();
  axis_fifo_pipelined_mem_if #(.width_p(8), .addr_width_p(2), .pipe_p(1)) if1 ();

  axis_fifo_pipelined_mem #(.width_p(8), .els_p(16), .pipeline_output_p(2)) dut2 (
    .clk_i(clk), .reset_i(reset), .bus(if2));
  axis_fifo_pipelined_mem #(.width_p(8), .els_p(16), .pipeline_output_p(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .bus(if3));
  axis_fifo_pipelined_mem #(.width_p(8), .els_p(4), .pipeline_output_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .bus(if1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    checks++; if (if2.r_data_o !== 8'h00) begin errors++; $display("FAIL reset_p2 got %h want 00", if2.r_data_o); end
    checks++; if (if3.r_data_o !== 8'h00) begin errors++; $display("FAIL reset_p3 got %h want 00", if3.r_data_o); end
    checks++; if (if1.r_data_o !== 8'h00) begin errors++; $display("FAIL reset_p1 got %h want 00", if1.r_data_o); end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    if2.w_v_i = 1'b1; if2.w_addr_i = 4'd3; if2.w_data_i = 8'hA5;
    step();
    if2.w_v_i = 1'b0;
    if2.r_v_i = 1'b1; if2.r_addr_i = 4'd3; sb2.push_back(8'hA5);
    step();
    if2.r_v_i = 1'b0;
    checks++; if (if2.r_data_o !== 8'h00) begin errors++; $display("FAIL wr_early got %h want 00", if2.r_data_o); end
    step();
    exp_v = sb2.pop_front();
    checks++; if (if2.r_data_o !== exp_v) begin errors++; $display("FAIL wr_latency got %h want %h", if2.r_data_o, exp_v); end
  endtask

  task automatic test_read_during_write();
    if2.w_v_i = 1'b1; if2.w_addr_i = 4'd5; if2.w_data_i = 8'h22;
    step();
    if2.w_data_i = 8'h11;
    if2.r_v_i = 1'b1; if2.r_addr_i = 4'd5; sb2.push_back(8'h22);
    step();
    if2.w_v_i = 1'b0; if2.r_v_i = 1'b0;
    step();
    exp_v = sb2.pop_front();
    checks++; if (if2.r_data_o !== exp_v) begin errors++; $display("FAIL rdw_old got %h want %h", if2.r_data_o, exp_v); end
    if2.r_v_i = 1'b1; sb2.push_back(8'h11);
    step();
    if2.r_v_i = 1'b0;
    step();
    exp_v = sb2.pop_front();
    checks++; if (if2.r_data_o !== exp_v) begin errors++; $display("FAIL rdw_new got %h want %h", if2.r_data_o, exp_v); end
  endtask

  task automatic test_stall();
    if3.output_ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      if3.w_v_i = 1'b1; if3.w_addr_i = 4'(i); if3.w_data_i = 8'(8'h30 + i);
      step();
    end
    if3.w_v_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if3.r_v_i = 1'b1; if3.r_addr_i = 4'(i); sb3.push_back(8'(8'h30 + i));
      step();
    end
    if3.r_v_i = 1'b0; if3.output_ready_i = 1'b0; if3.valid_pipe_reg_i = 3'b111;
    exp_v = sb3.pop_front();
    checks++; if (if3.r_data_o !== exp_v) begin errors++; $display("FAIL stall_first got %h want %h", if3.r_data_o, exp_v); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (if3.r_data_o !== exp_v) begin errors++; $display("FAIL stall_hold%0d got %h want %h", c, if3.r_data_o, exp_v); end
    end
    if3.output_ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      exp_v = sb3.pop_front();
      checks++; if (if3.r_data_o !== exp_v) begin errors++; $display("FAIL stall_resume%0d got %h want %h", c, if3.r_data_o, exp_v); end
    end
  endtask

  task automatic test_bubble_collapse();
    if3.output_ready_i = 1'b1; if3.valid_pipe_reg_i = 3'b111;
    // Queue order mirrors stages [2,1,0].
    for (int i = 1; i <= 3; i++) begin
      if3.r_v_i = 1'b1; if3.r_addr_i = 4'(i); sb3.push_back(8'(8'h30 + i));
      step();
    end
    if3.r_v_i = 1'b0; if3.output_ready_i = 1'b0; if3.valid_pipe_reg_i = 3'b101;
    step();
    sb3.delete(1);
    checks++; if (if3.r_data_o !== sb3[0]) begin errors++; $display("FAIL bubble_hold got %h want %h", if3.r_data_o, sb3[0]); end
    if3.output_ready_i = 1'b1; if3.valid_pipe_reg_i = 3'b111;
    step();
    void'(sb3.pop_front());
    checks++; if (if3.r_data_o !== sb3[0]) begin errors++; $display("FAIL bubble_shift got %h want %h", if3.r_data_o, sb3[0]); end
    sb3.delete();
  endtask

  task automatic test_reset_midstream();
    reset = 1'b1;
    if2.w_v_i = 1'b1; if2.w_addr_i = 4'd3; if2.w_data_i = 8'hEE;
    if2.r_v_i = 1'b1; if2.r_addr_i = 4'd5;
    step();
    checks++; if (if2.r_data_o !== 8'h00) begin errors++; $display("FAIL midreset_zero got %h want 00", if2.r_data_o); end
    reset = 1'b0; if2.w_v_i = 1'b0;
    if2.r_addr_i = 4'd3; sb2.push_back(8'hA5);
    step();
    if2.r_v_i = 1'b0;
    step();
    exp_v = sb2.pop_front();
    checks++; if (if2.r_data_o !== exp_v) begin errors++; $display("FAIL midreset_keep got %h want %h", if2.r_data_o, exp_v); end
  endtask

  task automatic test_p1_wrap();
    logic [1:0] seq [5];
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if1.w_v_i = 1'b1; if1.w_addr_i = 2'(i); if1.w_data_i = 8'(8'hC0 + i);
      step();
    end
    if1.w_v_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if1.r_v_i = 1'b1; if1.r_addr_i = seq[i]; sb1.push_back(8'(8'hC0 + seq[i]));
      step();
      exp_v = sb1.pop_front();
      checks++; if (if1.r_data_o !== exp_v) begin errors++; $display("FAIL p1_read%0d got %h want %h", i, if1.r_data_o, exp_v); end
    end
    if1.r_v_i = 1'b0;
  endtask

  initial begin
    if2.w_v_i = 1'b0; if2.w_addr_i = '0; if2.w_data_i = '0; if2.r_v_i = 1'b0; if2.r_addr_i = '0;
    if2.output_ready_i = 1'b1; if2.valid_pipe_reg_i = '1;
    if3.w_v_i = 1'b0; if3.w_addr_i = '0; if3.w_data_i = '0; if3.r_v_i = 1'b0; if3.r_addr_i = '0;
    if3.output_ready_i = 1'b1; if3.valid_pipe_reg_i = '1;
    if1.w_v_i = 1'b0; if1.w_addr_i = '0; if1.w_data_i = '0; if1.r_v_i = 1'b0; if1.r_addr_i = '0;
    if1.output_ready_i = 1'b1; if1.valid_pipe_reg_i = '1;
    test_reset();
    test_write_read();
    test_read_during_write();
    test_stall();
    test_bubble_collapse();
    test_reset_midstream();
    test_p1_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
